// File: rtl/cache_bus_arbiter.sv
// Shares one memory bus between the L1 instruction-miss and data-miss/writeback ports.
// Optional build macro CACHE_ARB_DATA_PRIORITY_EN: data port always wins on contention.
module cache_bus_arbiter #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int BEATS          = 8,
  parameter logic [BUS_TAG_WIDTH-1:0] TAG_READ  = 13'h1100,
  parameter logic [BUS_TAG_WIDTH-1:0] TAG_WRITE = 13'h1200
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ireq_valid,
  input  logic [BUS_DATA_WIDTH-1:0] ireq_addr,
  output logic                      ireq_ready,
  output logic                      iresp_valid,
  output logic [BUS_DATA_WIDTH-1:0] iresp_data,
  output logic                      iresp_last,
  input  logic                      dreq_valid,
  input  logic                      dreq_write,
  input  logic [BUS_DATA_WIDTH-1:0] dreq_addr,
  output logic                      dreq_ready,
  input  logic [BUS_DATA_WIDTH-1:0] dwdata,
  output logic                      dwdata_ready,
  output logic                      dresp_valid,
  output logic [BUS_DATA_WIDTH-1:0] dresp_data,
  output logic                      dresp_last,
  output logic                      bus_reqcyc,
  input  logic                      bus_reqack,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_respcyc,
  output logic                      bus_respack,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic [1:0]                dbg_state
);

  // Handshakes: a requester holds *_valid until its one-cycle *_ready grant pulse;
  // bus transfers complete on cycles where cyc and ack are both high.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADDR  = 2'd1,
    S_WDATA = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [2:0] LAST_BEAT = 3'(BEATS - 1);

  state_t                    state_q, state_d;
  logic                      owner_q, owner_d;          // 1 = data port
  logic                      is_write_q, is_write_d;
  logic [2:0]                beat_q, beat_d;
  logic                      last_grant_q, last_grant_d; // 1 = data port
  logic [BUS_DATA_WIDTH-1:0] addr_q, addr_d;
  logic                      grant_i, grant_d;

  // Response tag is not needed with a single outstanding transaction.
  logic unused_resptag;
  assign unused_resptag = ^bus_resptag;

  // Grant is suppressed while reset is held so no request is consumed and lost.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (reset && state_q == S_IDLE) begin
      if (ireq_valid && dreq_valid) begin
`ifdef CACHE_ARB_DATA_PRIORITY_EN
        grant_d = 1'b1;
`else
        if (last_grant_q) grant_i = 1'b1;
        else              grant_d = 1'b1;
`endif
      end else if (ireq_valid) begin
        grant_i = 1'b1;
      end else if (dreq_valid) begin
        grant_d = 1'b1;
      end
    end
  end

`ifdef CACHE_ARB_DATA_PRIORITY_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant_q;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      is_write_q   <= 1'b0;
      beat_q       <= 3'd0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      is_write_q   <= is_write_d;
      beat_q       <= beat_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    is_write_d   = is_write_q;
    beat_d       = beat_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    case (state_q)
      S_IDLE: begin
        if (grant_i) begin
          owner_d      = 1'b0;
          is_write_d   = 1'b0;
          addr_d       = ireq_addr;
          last_grant_d = 1'b0;
          state_d      = S_ADDR;
        end else if (grant_d) begin
          owner_d      = 1'b1;
          is_write_d   = dreq_write;
          addr_d       = dreq_addr;
          last_grant_d = 1'b1;
          state_d      = S_ADDR;
        end
      end
      S_ADDR: begin
        if (bus_reqack) begin
          beat_d  = 3'd0;
          state_d = is_write_q ? S_WDATA : S_RESP;
        end
      end
      S_WDATA: begin
        if (bus_reqack) begin
          beat_d = beat_q + 3'd1;
          if (beat_q == LAST_BEAT) state_d = S_IDLE;
        end
      end
      S_RESP: begin
        if (bus_respcyc) begin
          beat_d = beat_q + 3'd1;
          if (beat_q == LAST_BEAT) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ireq_ready   = 1'b0;
    dreq_ready   = 1'b0;
    iresp_valid  = 1'b0;
    iresp_data   = '0;
    iresp_last   = 1'b0;
    dresp_valid  = 1'b0;
    dresp_data   = '0;
    dresp_last   = 1'b0;
    dwdata_ready = 1'b0;
    bus_reqcyc   = 1'b0;
    bus_req      = '0;
    bus_reqtag   = '0;
    bus_respack  = 1'b0;
    case (state_q)
      S_IDLE: begin
        ireq_ready = grant_i;
        dreq_ready = grant_d;
      end
      S_ADDR: begin
        bus_reqcyc = 1'b1;
        bus_req    = addr_q;
        bus_reqtag = is_write_q ? TAG_WRITE : TAG_READ;
      end
      S_WDATA: begin
        bus_reqcyc   = 1'b1;
        bus_req      = dwdata;
        bus_reqtag   = TAG_WRITE;
        dwdata_ready = bus_reqack;
      end
      S_RESP: begin
        bus_respack = bus_respcyc;
        if (owner_q) begin
          dresp_valid = bus_respcyc;
          dresp_data  = bus_resp;
          dresp_last  = bus_respcyc && (beat_q == LAST_BEAT);
        end else begin
          iresp_valid = bus_respcyc;
          iresp_data  = bus_resp;
          iresp_last  = bus_respcyc && (beat_q == LAST_BEAT);
        end
      end
      default: ;
    endcase
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed, table-driven bench for cache_bus_arbiter plus multi-cycle corner sequences.
// Honours CACHE_ARB_DATA_PRIORITY_EN for the contention expectations.
module tb_cache_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid, ireq_ready, iresp_valid, iresp_last;
  logic [63:0] ireq_addr, iresp_data;
  logic        dreq_valid, dreq_write, dreq_ready, dwdata_ready;
  logic        dresp_valid, dresp_last;
  logic [63:0] dreq_addr, dwdata, dresp_data;
  logic        bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
  logic [63:0] bus_req, bus_resp;
  logic [12:0] bus_reqtag, bus_resptag;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cache_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .ireq_ready(ireq_ready),
    .iresp_valid(iresp_valid), .iresp_data(iresp_data), .iresp_last(iresp_last),
    .dreq_valid(dreq_valid), .dreq_write(dreq_write), .dreq_addr(dreq_addr),
    .dreq_ready(dreq_ready), .dwdata(dwdata), .dwdata_ready(dwdata_ready),
    .dresp_valid(dresp_valid), .dresp_data(dresp_data), .dresp_last(dresp_last),
    .bus_reqcyc(bus_reqcyc), .bus_reqack(bus_reqack), .bus_req(bus_req),
    .bus_reqtag(bus_reqtag), .bus_respcyc(bus_respcyc), .bus_respack(bus_respack),
    .bus_resp(bus_resp), .bus_resptag(bus_resptag), .dbg_state(dbg_state)
  );

  typedef struct {
    logic        iv, dv, dw, ack, rcyc;
    logic [63:0] dwd, resp;
    logic        irdy, drdy, reqcyc;
    logic [63:0] req;
    logic [12:0] tag;
    logic        rack, ivld, ilast, dvld, dlast, wrdy;
    logic [1:0]  st;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t blank();
    vec_t v;
    v = '{default: 0};
    return v;
  endfunction

  task automatic t_idle(input logic iv, dv, dw, rcyc, irdy, drdy);
    vec_t v = blank();
    v.iv = iv; v.dv = dv; v.dw = dw; v.rcyc = rcyc;
    v.irdy = irdy; v.drdy = drdy; v.st = 2'd0;
    vq.push_back(v);
  endtask

  task automatic t_addr(input logic ack, rcyc, input logic [63:0] req, input logic [12:0] tag);
    vec_t v = blank();
    v.ack = ack; v.rcyc = rcyc;
    v.reqcyc = 1'b1; v.req = req; v.tag = tag; v.st = 2'd1;
    vq.push_back(v);
  endtask

  task automatic t_wbeat(input logic ack, input logic [63:0] dwd);
    vec_t v = blank();
    v.ack = ack; v.dwd = dwd;
    v.reqcyc = 1'b1; v.req = dwd; v.tag = 13'h1200; v.wrdy = ack; v.st = 2'd2;
    vq.push_back(v);
  endtask

  task automatic t_rbeat(input logic rcyc, input logic [63:0] resp, input logic own_d, last);
    vec_t v = blank();
    v.rcyc = rcyc; v.resp = resp; v.rack = rcyc; v.st = 2'd3;
    if (own_d) begin v.dvld = rcyc; v.dlast = last; end
    else       begin v.ivld = rcyc; v.ilast = last; end
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive_idle_inputs();
    ireq_valid = 0; dreq_valid = 0; dreq_write = 0;
    bus_reqack = 0; bus_respcyc = 0; bus_resp = 0; dwdata = 0;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b0;
    drive_idle_inputs();
    repeat (cycles) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int    grants, last_g, ib, db, ilast_at, n;
    int    order[4];
    string nm;

    ireq_addr = 64'h1000; dreq_addr = 64'h2040; bus_resptag = 13'h0;
    reset = 1'b0;
    drive_idle_inputs();

    // Reset state with both requesters pushing: nothing may be granted
    ireq_valid = 1; dreq_valid = 1;
    repeat (2) @(posedge clk);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      chk("rst_ireq_ready", ireq_ready, 0);
      chk("rst_dreq_ready", dreq_ready, 0);
      chk("rst_reqcyc", bus_reqcyc, 0);
      chk("rst_req", bus_req, 0);
      chk("rst_reqtag", bus_reqtag, 0);
      chk("rst_respack", bus_respack, 0);
      chk("rst_state", dbg_state, 0);
    end
    @(negedge clk);
    drive_idle_inputs();
    reset = 1'b1;

    // Lone I read with spurious respcyc in IDLE and ADDR
    t_idle(1, 0, 0, 1, 1, 0);
    t_addr(0, 1, 64'h1000, 13'h1100);
    t_addr(1, 0, 64'h1000, 13'h1100);
    for (int k = 0; k < 8; k++) t_rbeat(1'b1, 64'hB0 + k, 1'b0, k == 7);
    // D writeback with a 3-cycle ack stall on beat 4; dreq_write dropped after grant
    t_idle(0, 1, 1, 0, 0, 1);
    t_addr(0, 0, 64'h2040, 13'h1200);
    t_addr(1, 0, 64'h2040, 13'h1200);
    for (int k = 0; k < 4; k++) t_wbeat(1'b1, 64'hA0 + k);
    repeat (3) t_wbeat(1'b0, 64'hA4);
    for (int k = 4; k < 8; k++) t_wbeat(1'b1, 64'hA0 + k);
    // D read with one idle bus cycle between beats 0 and 1
    t_idle(0, 1, 0, 0, 0, 1);
    t_addr(1, 0, 64'h2040, 13'h1100);
    t_rbeat(1'b1, 64'hC0, 1'b1, 1'b0);
    t_rbeat(1'b0, 64'hC1, 1'b1, 1'b0);
    for (int k = 1; k < 8; k++) t_rbeat(1'b1, 64'hC0 + k, 1'b1, k == 7);
    t_idle(0, 0, 0, 1, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      ireq_valid = vq[i].iv; dreq_valid = vq[i].dv; dreq_write = vq[i].dw;
      bus_reqack = vq[i].ack; bus_respcyc = vq[i].rcyc;
      dwdata = vq[i].dwd; bus_resp = vq[i].resp;
      #1;
      nm = $sformatf("v%0d", i);
      chk({nm, "_ireq_ready"}, ireq_ready, vq[i].irdy);
      chk({nm, "_dreq_ready"}, dreq_ready, vq[i].drdy);
      chk({nm, "_reqcyc"}, bus_reqcyc, vq[i].reqcyc);
      chk({nm, "_req"}, bus_req, vq[i].req);
      chk({nm, "_reqtag"}, bus_reqtag, vq[i].tag);
      chk({nm, "_respack"}, bus_respack, vq[i].rack);
      chk({nm, "_iresp_valid"}, iresp_valid, vq[i].ivld);
      chk({nm, "_iresp_last"}, iresp_last, vq[i].ilast);
      chk({nm, "_dresp_valid"}, dresp_valid, vq[i].dvld);
      chk({nm, "_dresp_last"}, dresp_last, vq[i].dlast);
      chk({nm, "_dwdata_ready"}, dwdata_ready, vq[i].wrdy);
      chk({nm, "_state"}, dbg_state, vq[i].st);
      if (vq[i].ivld) chk({nm, "_iresp_data"}, iresp_data, vq[i].resp);
      if (vq[i].dvld) chk({nm, "_dresp_data"}, dresp_data, vq[i].resp);
    end

    // Contention out of reset: both held continuously for 4 transactions
    do_reset(2);
    @(negedge clk);
    ireq_valid = 1; dreq_valid = 1; dreq_write = 0;
    bus_reqack = 1; bus_respcyc = 1; bus_resp = 64'h55;
    grants = 0; last_g = -100; ib = 0; db = 0;
    for (int c = 0; c < 200 && grants < 4; c++) begin
      #1;
      ib += int'(iresp_valid);
      db += int'(dresp_valid);
      if (ireq_ready && dreq_ready) chk("rr_double_grant", 1, 0);
      if (ireq_ready || dreq_ready) begin
        order[grants] = dreq_ready ? 1 : 0;
        if (grants > 0) chk($sformatf("rr_gap%0d", grants), c - last_g, 10);
        last_g = c;
        grants++;
      end
      @(negedge clk);
    end
    chk("rr_grant_count", grants, 4);
    ireq_valid = 0; dreq_valid = 0;
    for (int c = 0; c < 14; c++) begin
      #1;
      ib += int'(iresp_valid);
      db += int'(dresp_valid);
      @(negedge clk);
    end
`ifdef CACHE_ARB_DATA_PRIORITY_EN
    for (int g = 0; g < 4; g++) chk($sformatf("prio_order%0d", g), order[g], 1);
    chk("prio_ibeats", ib, 0);
    chk("prio_dbeats", db, 32);
`else
    for (int g = 0; g < 4; g++) chk($sformatf("rr_order%0d", g), order[g], g % 2);
    chk("rr_ibeats", ib, 16);
    chk("rr_dbeats", db, 16);
`endif
    chk("rr_end_state", dbg_state, 0);

    // Reset asserted during RESP beat 3
    drive_idle_inputs();
    ireq_valid = 1;
    @(negedge clk);
    ireq_valid = 0; bus_reqack = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus_reqack = 0; bus_respcyc = 1; bus_resp = 64'hD0 + k;
      if (k == 3) reset = 1'b0;
      #1;
      chk($sformatf("rst_resp_beat%0d_valid", k), iresp_valid, 1);
    end
    @(negedge clk); #1;
    chk("rst_resp_reqcyc", bus_reqcyc, 0);
    chk("rst_resp_respack", bus_respack, 0);
    chk("rst_resp_ivalid", iresp_valid, 0);
    chk("rst_resp_state", dbg_state, 0);
    reset = 1'b1;
    bus_respcyc = 0;

    // Following I read completes normally with 8 beats
    @(negedge clk);
    ireq_valid = 1; #1;
    chk("post_rst_grant", ireq_ready, 1);
    @(negedge clk);
    ireq_valid = 0; bus_reqack = 1; #1;
    chk("post_rst_addr", bus_req, 64'h1000);
    n = 0; ilast_at = -1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus_reqack = 0; bus_respcyc = 1; bus_resp = 64'hE0 + k;
      #1;
      n += int'(iresp_valid);
      if (iresp_last) ilast_at = k;
      if (iresp_valid) chk($sformatf("post_rst_data%0d", k), iresp_data, 64'hE0 + k);
    end
    @(negedge clk);
    bus_respcyc = 0; #1;
    chk("post_rst_beats", n, 8);
    chk("post_rst_last_at", ilast_at, 7);
    chk("post_rst_state", dbg_state, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_bus_arbiter.md
# cache_bus_arbiter

Shares the single memory bus between the L1 instruction-miss port and the L1 data-miss/writeback port. It sequences one transaction at a time: an address phase, then either 8 write-data beats or 8 read-response beats for a 64-byte block. Read beats are routed back to the requester that owns the transaction. It sits between the cache and the top-level bus pins.

## Interface
- BUS_DATA_WIDTH, 64, bus data/address width
- BUS_TAG_WIDTH, 13, bus tag width
- BEATS, 8, beats per block (64 B / 8 B)
- TAG_READ, 13'h1100, tag driven on a read address phase
- TAG_WRITE, 13'h1200, tag driven on a write address phase and on write-data beats

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- ireq_valid  in  1  instruction block read request; held until ireq_ready
- ireq_addr  in  64  block-aligned read address
- ireq_ready  out  1  one-cycle grant pulse
- iresp_valid / iresp_data / iresp_last  out  1/64/1  instruction read beats
- dreq_valid  in  1  data request; held until dreq_ready
- dreq_write  in  1  1 = writeback, 0 = read
- dreq_addr  in  64  block-aligned address
- dreq_ready  out  1  one-cycle grant pulse
- dwdata  in  64  current writeback beat
- dwdata_ready  out  1  current dwdata beat consumed; requester advances
- dresp_valid / dresp_data / dresp_last  out  1/64/1  data read beats
- bus_reqcyc  out  1;  bus_reqack  in  1;  bus_req  out  64;  bus_reqtag  out  13
- bus_respcyc  in  1;  bus_respack  out  1;  bus_resp  in  64;  bus_resptag  in  13

## Operation
- FSM states: IDLE, ADDR, WDATA, RESP. Registers: owner (I/D), is_write, beat counter (3 bits), last_grant.
- IDLE
  - If a request is valid: pulse its ready, latch the address, owner and write flag, then go to ADDR.
  - Contention: round-robin. Grant the requester not named in last_grant, then update last_grant.
- ADDR
  - bus_reqcyc=1, bus_req=latched address, bus_reqtag = TAG_WRITE if is_write, else TAG_READ.
  - Hold until bus_reqack. Then go to WDATA if is_write, else RESP, and clear the beat counter.
- WDATA
  - bus_reqcyc=1, bus_req=dwdata, bus_reqtag=TAG_WRITE.
  - dwdata_ready = bus_reqack (combinational); the counter increments on each ack.
  - The ack of beat 7 returns the FSM to IDLE.
- RESP
  - bus_respack = bus_respcyc (combinational).
  - The owner's resp_valid = bus_respcyc and resp_data = bus_resp in the same cycle; the other port stays silent.
  - resp_last = 1 on beat 7, and the FSM goes to IDLE the next cycle. bus_resptag is not checked (single outstanding transaction).
- Outside RESP, bus_respcyc is ignored and bus_respack stays 0.
- Counter wraps 7→0 only on a state exit. No partial blocks.

## Timing
- Reset values: bus_reqcyc=0, bus_req=0, bus_reqtag=0, bus_respack=0, all ready/valid/last outputs 0, state IDLE, last_grant=D (so I wins the first tie).
- A reset asserted in any state takes effect at the next edge:
  - the in-flight transaction is abandoned;
  - bus_reqcyc falls at that edge;
  - no further acks or beats are forwarded.
- Grant latency: ready pulses in the first IDLE cycle that valid is seen; bus_reqcyc rises the next cycle.
- The address phase lasts at least 1 cycle and extends until bus_reqack.
- Back-to-back: after the final beat, the next grant occurs at the earliest in the IDLE cycle that follows. There are at least 2 cycles between consecutive address phases.
- A request that arrives during an active transaction waits. Its valid must stay held, and ready is not pulsed.
- dreq_write is sampled only at grant.

## Configuration
- CACHE_ARB_DATA_PRIORITY_EN
  - Defined: on contention the data port always wins, and last_grant is unused.
  - Undefined: round-robin as above.
- Single-requester behaviour is identical in both builds.

## Test plan
- Lone I read: ireq_addr=0x1000 → ireq_ready 1 cycle, then bus_req=0x1000 with tag 0x1100. After ack, 8 bus_respcyc beats 0..7 → iresp_valid on each, iresp_last on the 8th, dresp_valid never set.
- D writeback: dreq_write=1, addr 0x2040, dwdata stream A0..A7 → address phase with tag 0x1200, then 8 write beats. bus_reqack stalled 3 cycles on beat 4 → bus_req holds A4 and dwdata_ready stays 0.
- Simultaneous I and D requests out of reset → I granted first, D granted after I's last beat. With CACHE_ARB_DATA_PRIORITY_EN defined → D granted first.
- Round-robin check: I and D held continuously for 4 transactions → grant order I, D, I, D.
- Spurious bus_respcyc while in IDLE or ADDR → bus_respack=0 and no resp_valid.
- Reset asserted during RESP beat 3 → next cycle bus_reqcyc=0, bus_respack=0, FSM in IDLE. A following I read completes normally with 8 beats.
